// File: rtl/divisor_restoring_n.sv
// divisor_restoring_n
// Sequential restoring divider: N-bit dividend by N-bit divisor, one quotient
// bit per clock, unsigned or two's-complement per operation. Signed operands
// are reduced to magnitudes on acceptance and the signs are reapplied in FIX.
module divisor_restoring_n #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_op,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         div_zero
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIX    = 2'd2
    } state_t;

    state_t state, state_nx;

    logic          sign_a, sign_b, zero_div;
    logic [N-1:0]  mag_b;
    logic [N-1:0]  quo;   // dividend shifts out of the top, quotient bits in at the bottom
    logic [N-1:0]  rem;   // partial remainder; always below |b| once stored, so N bits hold it
    logic [CW-1:0] cnt;

    logic          sa_in, sb_in, b_zero;
    logic [N-1:0]  mag_a_in, mag_b_in;
    logic [N:0]    shifted, trial;

    // Operand magnitudes and the trial subtraction for the current iteration
    always_comb begin
        sa_in    = signed_op & a_in[N-1];
        sb_in    = signed_op & b_in[N-1];
        b_zero   = (b_in == '0);
        mag_a_in = sa_in ? -a_in : a_in;
        mag_b_in = sb_in ? -b_in : b_in;
        shifted  = {rem, quo[N-1]};
        trial    = shifted - {1'b0, mag_b};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = b_zero ? FIX : DIVIDE;
            DIVIDE:  if (cnt == CW'(N - 1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            zero_div <= 1'b0;
            mag_b    <= '0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_a   <= sa_in;
                        sign_b   <= sb_in;
                        zero_div <= b_zero;
                        mag_b    <= mag_b_in;
                        // On divide-by-zero the raw dividend is parked here for r
                        quo      <= b_zero ? a_in : mag_a_in;
                        rem      <= '0;
                        cnt      <= '0;
                    end
                end
                DIVIDE: begin
                    // A restored value is below |b|, so its top bit is always zero
                    rem <= trial[N] ? shifted[N-1:0] : trial[N-1:0];
                    quo <= {quo[N-2:0], ~trial[N]};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    done     <= 1'b1;
                    div_zero <= zero_div;
                    if (zero_div) begin
                        q <= '1;
                        r <= quo;
                    end else begin
                        q <= (sign_a ^ sign_b) ? -quo : quo;
                        r <= sign_a ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_restoring_n.sv
// Testbench for divisor_restoring_n: directed cases at N=7, randomized N=7
// operations and an exhaustive N=4 sweep, all against an integer-arithmetic model.
module tb_divisor_restoring_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start7 = 1'b0, s7 = 1'b0;
    logic [6:0] a7 = '0, b7 = '0;
    logic       busy7, done7, dz7;
    logic [6:0] q7, r7;

    logic       start4 = 1'b0, s4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, dz4;
    logic [3:0] q4, r4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    divisor_restoring_n #(.N(7)) dut7 (
        .clk(clk), .rst(rst), .start(start7), .signed_op(s7), .a_in(a7), .b_in(b7),
        .busy(busy7), .done(done7), .q(q7), .r(r7), .div_zero(dz7)
    );

    divisor_restoring_n #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_op(s4), .a_in(a4), .b_in(b4),
        .busy(busy4), .done(done4), .q(q4), .r(r4), .div_zero(dz4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Truncating division computed with plain signed integers
    function automatic void model(input int n, input bit s, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r, output bit dz);
        longint m  = (64'sd1 <<< n) - 1;
        longint sa = longint'(a);
        longint sb = longint'(b);
        longint qq, rr;
        dz = (b == 0);
        if (dz) begin
            q = 32'(m);
            r = a;
            return;
        end
        if (s) begin
            if (a[n-1]) sa = sa - (64'sd1 <<< n);
            if (b[n-1]) sb = sb - (64'sd1 <<< n);
        end
        qq = sa / sb;
        rr = sa % sb;
        q  = 32'(qq & m);
        r  = 32'(rr & m);
    endfunction

    function automatic logic [31:0] get_q(input bit w);
        return w ? 32'(q7) : 32'(q4);
    endfunction
    function automatic logic [31:0] get_r(input bit w);
        return w ? 32'(r7) : 32'(r4);
    endfunction
    function automatic logic get_dz(input bit w);
        return w ? dz7 : dz4;
    endfunction
    function automatic logic get_done(input bit w);
        return w ? done7 : done4;
    endfunction
    function automatic logic get_busy(input bit w);
        return w ? busy7 : busy4;
    endfunction

    // Present operands, let the next edge sample them, then drop start
    task automatic launch(input bit w, input bit s, input logic [6:0] a, input logic [6:0] b);
        if (w) begin s7 = s; a7 = a; b7 = b; start7 = 1'b1; end
        else   begin s4 = s; a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1; end
        @(posedge clk);
        #1;
        start7 = 1'b0;
        start4 = 1'b0;
    endtask

    // Wait (bounded) for done; lat counts edges from the start edge
    task automatic wait_done(input bit w, input int base, output int lat,
                             output int busy_n, output bit hold_ok);
        logic [31:0] q0 = get_q(w);
        logic [31:0] r0 = get_r(w);
        logic        z0 = get_dz(w);
        lat = -1;
        busy_n = 0;
        hold_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (get_done(w)) begin
                lat = base + i - 1;
                break;
            end
            if (get_busy(w)) busy_n++;
            if (get_q(w) !== q0 || get_r(w) !== r0 || get_dz(w) !== z0) hold_ok = 1'b0;
        end
    endtask

    task automatic op(input bit w, input string tag, input bit s,
                      input logic [6:0] a, input logic [6:0] b);
        int          lat, busy_n, n, exp_lat;
        bit          hold_ok, ez;
        logic [31:0] eq, er;
        n = w ? 7 : 4;
        @(negedge clk);
        launch(w, s, a, b);
        wait_done(w, 0, lat, busy_n, hold_ok);
        model(n, s, w ? 32'(a) : 32'(a[3:0]), w ? 32'(b) : 32'(b[3:0]), eq, er, ez);
        exp_lat = ez ? 1 : n + 1;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_q"}, get_q(w), eq);
        check({tag, "_r"}, get_r(w), er);
        check({tag, "_dz"}, 32'(get_dz(w)), 32'(ez));
        check({tag, "_busy_n"}, 32'(busy_n), 32'(exp_lat));
        check({tag, "_busy_at_done"}, 32'(get_busy(w)), 32'd0);
        check({tag, "_hold"}, 32'(hold_ok), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(get_done(w)), 32'd0);
    endtask

    initial begin
        int  lat, busy_n;
        bit  hold_ok, saw;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy7", 32'(busy7), 0);
        check("rst_done7", 32'(done7), 0);
        check("rst_q7", 32'(q7), 0);
        check("rst_r7", 32'(r7), 0);
        check("rst_dz7", 32'(dz7), 0);
        check("rst_busy4", 32'(busy4), 0);
        check("rst_q4", 32'(q4), 0);

        // Unsigned 100/7
        op(1, "u100_7", 1'b0, 7'd100, 7'd7);
        check("u100_7_q_const", 32'(q7), 32'd14);
        check("u100_7_r_const", 32'(r7), 32'd2);

        // Signed -50/7 and 50/-7
        op(1, "s_m50_7", 1'b1, 7'h4E, 7'd7);
        check("s_m50_7_q_const", 32'(q7), 32'h79);
        check("s_m50_7_r_const", 32'(r7), 32'h7F);
        op(1, "s_50_m7", 1'b1, 7'd50, 7'h79);
        check("s_50_m7_q_const", 32'(q7), 32'h79);
        check("s_50_m7_r_const", 32'(r7), 32'h01);

        // Divide by zero, both modes, then a normal op clears the flag
        op(1, "u45_0", 1'b0, 7'd45, 7'd0);
        check("u45_0_q_const", 32'(q7), 32'h7F);
        check("u45_0_r_const", 32'(r7), 32'd45);
        check("u45_0_dz_const", 32'(dz7), 32'd1);
        op(1, "s45_0", 1'b1, 7'd45, 7'd0);
        op(1, "u10_3", 1'b0, 7'd10, 7'd3);
        check("u10_3_q_const", 32'(q7), 32'd3);
        check("u10_3_r_const", 32'(r7), 32'd1);
        check("u10_3_dz_const", 32'(dz7), 32'd0);

        // Signed overflow and the same bits unsigned
        op(1, "s_ovf", 1'b1, 7'h40, 7'h7F);
        check("s_ovf_q_const", 32'(q7), 32'h40);
        check("s_ovf_r_const", 32'(r7), 32'd0);
        op(1, "u64_127", 1'b0, 7'h40, 7'h7F);
        check("u64_127_q_const", 32'(q7), 32'd0);
        check("u64_127_r_const", 32'(r7), 32'd64);

        // start while busy is ignored
        @(negedge clk);
        launch(1, 1'b0, 7'd20, 7'd6);
        @(negedge clk);
        @(negedge clk);
        a7 = 7'd99; b7 = 7'd9; start7 = 1'b1;
        @(negedge clk);
        start7 = 1'b0;
        wait_done(1, 3, lat, busy_n, hold_ok);
        check("ign_lat", 32'(lat), 32'd8);
        check("ign_q", 32'(q7), 32'd3);
        check("ign_r", 32'(r7), 32'd2);

        // start in the done cycle is accepted
        launch(1, 1'b0, 7'd99, 7'd9);
        wait_done(1, 0, lat, busy_n, hold_ok);
        check("b2b_lat", 32'(lat), 32'd8);
        check("b2b_q", 32'(q7), 32'd11);
        check("b2b_r", 32'(r7), 32'd0);
        check("b2b_hold", 32'(hold_ok), 32'd1);

        // Reset mid-operation aborts without done
        @(negedge clk);
        launch(1, 1'b0, 7'd127, 7'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy7), 32'd0);
        check("abort_done", 32'(done7), 32'd0);
        check("abort_q", 32'(q7), 32'd0);
        check("abort_r", 32'(r7), 32'd0);
        check("abort_dz", 32'(dz7), 32'd0);
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done7 || busy7) saw = 1'b1;
        end
        check("abort_quiet", 32'(saw), 32'd0);
        op(1, "u9_4", 1'b0, 7'd9, 7'd4);
        check("u9_4_q_const", 32'(q7), 32'd2);
        check("u9_4_r_const", 32'(r7), 32'd1);

        // Randomized N=7 operations
        for (int i = 0; i < 40; i++) begin
            logic [6:0] ra, rb;
            bit         rs;
            rs = 1'($urandom_range(0, 1));
            ra = 7'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom);
            op(1, $sformatf("rnd%0d", i), rs, ra, rb);
        end

        // Exhaustive N=4 sweep
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    op(0, $sformatf("n4_s%0d_%0d_%0d", s, a, b), 1'(s), 7'(a), 7'(b));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
